pixel_scan_controller: RTL
==========================

Name: pixel_scan_controller

Overview:
- Raster sequencer for the Mandelbrot datapath.
- Walks every pixel (x, y) of a frame and drives one shared linear scaler, time-multiplexed between the real and imaginary axes.
- Presents each pixel's complex coordinate (re, im) to the downstream iteration engine over a valid/ready handshake.
- Sits between the view-configuration registers and the iteration engine.

Parameters:
- H_PIXELS, 640: pixels per row; x runs 0..H_PIXELS-1.
- V_PIXELS, 480: rows per frame; y runs 0..V_PIXELS-1.
- SCALER_LATENCY, 1: clock cycles from a scaler_idx change to a valid scaler_out; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- re_offset  in  64  IEEE-754 double; real-axis offset.
- re_width  in  64  IEEE-754 double; real-axis span.
- im_offset  in  64  IEEE-754 double; imaginary-axis offset.
- im_width  in  64  IEEE-754 double; imaginary-axis span.
- scaler_idx  out  32  index driven to the shared scaler.
- scaler_offset  out  64  offset driven to the scaler.
- scaler_width  out  64  width driven to the scaler.
- scaler_out  in  64  scaled double returned by the scaler.
- pix_valid  out  1  pixel coordinate available.
- pix_ready  in  1  iteration engine accepts the coordinate.
- pix_x  out  16  pixel column.
- pix_y  out  16  pixel row.
- pix_re  out  64  real coordinate.
- pix_im  out  64  imaginary coordinate.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: pix_valid, busy, frame_done, pix_x, pix_y, pix_re, pix_im, scaler_idx, scaler_offset, scaler_width.
  - Reset asserted mid-frame aborts the frame immediately; no frame_done is emitted.
- Config latch: on start in IDLE, the four range inputs are registered internally. Input changes during a frame have no effect until the next start.
- States:
  - IDLE: busy=0. start -> SCALE_RE, with x=0, y=0, busy=1 from the next cycle.
  - SCALE_RE: drive scaler_idx=x, scaler_offset=re_offset_q, scaler_width=re_width_q; wait counter=SCALER_LATENCY. Next state WAIT_RE.
  - WAIT_RE: hold the scaler inputs; count down. At 0, capture scaler_out into pix_re and go to SCALE_IM.
  - SCALE_IM / WAIT_IM: same sequence with idx=y and the im_* values; capture into pix_im and go to PRESENT.
  - PRESENT: pix_valid=1; pix_x, pix_y, pix_re, pix_im held stable until pix_ready is sampled high.
- Advance on handshake (pix_valid & pix_ready):
  - If x < H_PIXELS-1: x+1, go to SCALE_RE.
  - Else if y < V_PIXELS-1: x=0, y+1, go to SCALE_RE.
  - Else: go to IDLE; frame_done=1 for exactly one cycle; busy=0 in that same cycle.
- Per-pixel timing (no backpressure): 2*(SCALER_LATENCY+1)+1 cycles per pixel. pix_valid deasserts for at least one cycle between pixels.
- pix_ready held high while pix_valid=0 is ignored.
- pix_valid never drops without a handshake.
- start while busy is ignored.
- start in the same cycle as frame_done (state already IDLE on the next edge) is honoured only if it arrives when state==IDLE.
- Counters are 16 bits. scaler_idx is x or y zero-extended to 32 bits.
- scaler_offset and scaler_width are the only values mixed onto the shared scaler. The block performs no floating-point arithmetic itself.

Optional Feature:
- Macro: PIXEL_SCAN_ROW_CACHE_EN.
- Defined:
  - pix_im is computed only for x=0 of each row; for x>0, WAIT_RE goes directly to PRESENT with pix_im unchanged.
  - Per-pixel latency for x>0 becomes (SCALER_LATENCY+1)+1 cycles.
- Undefined: both axes are scaled for every pixel, as described above.
- In both cases pix_re and pix_im values are identical for every pixel.

Test Plan:
- Reset mid-frame: H=4, V=2, latency=1. Assert reset_n=0 during pixel (2,0) -> all outputs 0 immediately, state IDLE, no frame_done; a following start restarts at (0,0).
- Full frame: H=4, V=2, pix_ready tied 1, re_offset=-2.0, re_width=3.0, im_offset=-1.0, im_width=2.0 with a model scaler -> 8 handshakes in order (0,0),(1,0)..(3,1); pix_re/pix_im match the model; frame_done one pulse; 5 cycles per pixel.
- Backpressure: pix_ready low 10 cycles at pixel (1,0) -> pix_valid and all pix_* stable for those 10 cycles; advance one cycle after ready.
- Start ignored: pulse start during pixel (2,1) with new ranges -> no restart; remaining pixels use the old ranges; the next frame after done uses the new ranges.
- Latency=3: H=2, V=1 -> scaler inputs held 4 cycles per axis; 9 cycles per pixel.
- Row cache (macro defined): H=4, V=2 -> scaler_idx=y only at x=0; pixel (3,1) arrives in 3 cycles; coordinate values identical to the non-cached run.

Source files
------------

// File: rtl/pixel_scan_controller.sv
// pixel_scan_controller: raster walker time-sharing one scaler between re/im axes; PIXEL_SCAN_ROW_CACHE_EN reuses pix_im across a row.
module pixel_scan_controller #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int SCALER_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] re_offset,
  input  logic [63:0] re_width,
  input  logic [63:0] im_offset,
  input  logic [63:0] im_width,
  output logic [31:0] scaler_idx,
  output logic [63:0] scaler_offset,
  output logic [63:0] scaler_width,
  input  logic [63:0] scaler_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [63:0] pix_re,
  output logic [63:0] pix_im,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [2:0] {IDLE, SCALE_RE, WAIT_RE, SCALE_IM, WAIT_IM, PRESENT} state_t;
  localparam logic [15:0] X_MAX = 16'(H_PIXELS - 1);
  localparam logic [15:0] Y_MAX = 16'(V_PIXELS - 1);
  localparam logic [15:0] LAT_M1 = 16'(SCALER_LATENCY - 1);
  state_t state, state_n;
  logic [15:0] x, y, x_n, y_n, cnt;
  logic [63:0] re_off_q, re_w_q, im_off_q, im_w_q;
  logic hs, cnt_zero;
  assign pix_valid = state == PRESENT;
  assign busy = state != IDLE;
  assign pix_x = x;
  assign pix_y = y;
  assign hs = pix_valid & pix_ready;
  assign cnt_zero = cnt == 16'd0;
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    case (state)
      IDLE: if (start) begin
        state_n = SCALE_RE;
        x_n = '0;
        y_n = '0;
      end
      SCALE_RE: state_n = WAIT_RE;
`ifdef PIXEL_SCAN_ROW_CACHE_EN
      WAIT_RE: if (cnt_zero) state_n = (x != 16'd0) ? PRESENT : SCALE_IM;
`else
      WAIT_RE: if (cnt_zero) state_n = SCALE_IM;
`endif
      SCALE_IM: state_n = WAIT_IM;
      WAIT_IM: if (cnt_zero) state_n = PRESENT;
      PRESENT: if (hs) begin
        state_n = (x < X_MAX || y < Y_MAX) ? SCALE_RE : IDLE;
        x_n = (x < X_MAX) ? x + 16'd1 : 16'd0;
        y_n = (x < X_MAX) ? y : (y < Y_MAX) ? y + 16'd1 : y;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      cnt <= '0;
      re_off_q <= '0;
      re_w_q <= '0;
      im_off_q <= '0;
      im_w_q <= '0;
      scaler_idx <= '0;
      scaler_offset <= '0;
      scaler_width <= '0;
      pix_re <= '0;
      pix_im <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      frame_done <= state == PRESENT && state_n == IDLE;
      cnt <= (state == SCALE_RE || state == SCALE_IM) ? LAT_M1 : cnt_zero ? cnt : cnt - 16'd1;
      if (state == IDLE && start) begin
        re_off_q <= re_offset;
        re_w_q <= re_width;
        im_off_q <= im_offset;
        im_w_q <= im_width;
      end
      // the first pixel loads the scaler in the same edge that latches the config
      if (state_n == SCALE_RE) begin
        scaler_idx <= {16'd0, x_n};
        scaler_offset <= (state == IDLE) ? re_offset : re_off_q;
        scaler_width <= (state == IDLE) ? re_width : re_w_q;
      end
      if (state_n == SCALE_IM) begin
        scaler_idx <= {16'd0, y_n};
        scaler_offset <= im_off_q;
        scaler_width <= im_w_q;
      end
      if (state == WAIT_RE && cnt_zero) pix_re <= scaler_out;
      if (state == WAIT_IM && cnt_zero) pix_im <= scaler_out;
    end
  end
endmodule
